// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator for the Sobel gradient stage.
// Optional sticky overrun output: define SOBEL_WIN_OVERRUN_EN.
module sobel_window_gen #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       frame_start,
  input  logic       pixel_valid,
  input  logic [7:0] pixel_in,
  output logic [7:0] P0,
  output logic [7:0] P1,
  output logic [7:0] P2,
  output logic [7:0] P3,
  output logic [7:0] P4,
  output logic [7:0] P5,
  output logic [7:0] P6,
  output logic [7:0] P7,
  output logic [7:0] P8,
  output logic       start_calculations,
  output logic       frame_done,
`ifdef SOBEL_WIN_OVERRUN_EN
  output logic       overrun,
`endif
  output logic       busy
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {
    IDLE, FILL, STREAM, DONE
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] col, col_nx, pc;
  logic [RW-1:0] row, row_nx, pr;
  logic          acc, last_col, win_ok;
  logic [7:0]    lb0 [IMG_WIDTH];
  logic [7:0]    lb1 [IMG_WIDTH];

  assign busy = (state == FILL) || (state == STREAM);

  // frame_start restarts the position so a same-cycle pixel lands at (0,0)
  always_comb begin
    acc      = pixel_valid && (frame_start || busy);
    pc       = frame_start ? '0 : col;
    pr       = frame_start ? '0 : row;
    last_col = (pc == CW'(IMG_WIDTH - 1));
    win_ok   = acc && (pr >= RW'(2)) && (pc >= CW'(2));
    state_nx = state;
    col_nx   = col;
    row_nx   = row;
    if (frame_start) begin
      state_nx = FILL;
      col_nx   = '0;
      row_nx   = '0;
    end
    if (acc) begin
      col_nx = last_col ? '0 : pc + 1'b1;
      row_nx = last_col ? pr + 1'b1 : pr;
    end
    unique case (state)
      IDLE: ;
      FILL:
        if (!frame_start && acc && last_col && pr == RW'(1))
          state_nx = STREAM;
      STREAM:
        if (!frame_start && acc && last_col
            && pr == RW'(IMG_HEIGHT - 1)) begin
          state_nx = DONE;
          row_nx   = '0;
          col_nx   = '0;
        end
      DONE:
        if (!frame_start) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state              <= IDLE;
      col                <= '0;
      row                <= '0;
      start_calculations <= 1'b0;
      frame_done         <= 1'b0;
      {P0, P1, P2}       <= '0;
      {P3, P4, P5}       <= '0;
      {P6, P7, P8}       <= '0;
    end else begin
      state              <= state_nx;
      col                <= col_nx;
      row                <= row_nx;
      start_calculations <= win_ok;
      frame_done         <= (state_nx == DONE);
      if (acc) begin
        P0 <= P1;
        P1 <= P2;
        P2 <= lb0[pc];
        P3 <= P4;
        P4 <= P5;
        P5 <= lb1[pc];
        P6 <= P7;
        P7 <= P8;
        P8 <= pixel_in;
      end
    end
  end

  // line buffer RAM is deliberately left unreset
  always_ff @(posedge clk) begin
    if (acc) begin
      lb0[pc] <= lb1[pc];
      lb1[pc] <= pixel_in;
    end
  end

`ifdef SOBEL_WIN_OVERRUN_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      overrun <= 1'b0;
    else if ((pixel_valid && !busy && !frame_start)
             || (frame_start && busy))
      overrun <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_sobel_window_gen.sv
// Directed bench for sobel_window_gen on a 4x4 image.
// Covers streaming, gaps, back-to-back frames, reset and abort.
module tb_sobel_window_gen;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       frame_start = 1'b0;
  logic       pixel_valid = 1'b0;
  logic [7:0] pixel_in = 8'h00;
  logic [7:0] P0, P1, P2, P3, P4, P5, P6, P7, P8;
  logic       start_calculations, frame_done, busy;
`ifdef SOBEL_WIN_OVERRUN_EN
  logic       overrun;
`endif

  sobel_window_gen #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H)
  ) dut (
    .clk               (clk),
    .n_rst             (n_rst),
    .frame_start       (frame_start),
    .pixel_valid       (pixel_valid),
    .pixel_in          (pixel_in),
    .P0                (P0),
    .P1                (P1),
    .P2                (P2),
    .P3                (P3),
    .P4                (P4),
    .P5                (P5),
    .P6                (P6),
    .P7                (P7),
    .P8                (P8),
    .start_calculations(start_calculations),
    .frame_done        (frame_done),
`ifdef SOBEL_WIN_OVERRUN_EN
    .overrun           (overrun),
`endif
    .busy              (busy)
  );

  always #5 clk = ~clk;

  logic [71:0] win;
  assign win = {P0, P1, P2, P3, P4, P5, P6, P7, P8};

  int          n_chk = 0;
  int          n_bad = 0;
  int          fd_cnt = 0;
  int          gap_cnt = 0;
  logic        vld_q = 1'b0;
  logic [71:0] win_q [$];
  logic [71:0] exp_q [$];

  always @(posedge clk) vld_q <= pixel_valid;

  always @(negedge clk) begin
    if (start_calculations) begin
      win_q.push_back(win);
      if (!vld_q) gap_cnt++;
    end
    if (frame_done) fd_cnt++;
  end

  task automatic chk(input string tag,
                     input logic [71:0] got,
                     input logic [71:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] val(input bit mode,
                                     input int r,
                                     input int c);
    logic [7:0] v;
    v = 8'(16 * r + c);
    return mode ? 8'hFF - v : v;
  endfunction

  function automatic logic [71:0] exp_win(input bit mode,
                                          input int r,
                                          input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w = {w[63:0], val(mode, r - 2 + i, c - 2 + j)};
    return w;
  endfunction

  task automatic push_exp(input bit mode);
    for (int r = 2; r < H; r++)
      for (int c = 2; c < W; c++)
        exp_q.push_back(exp_win(mode, r, c));
  endtask

  task automatic cyc(input bit fs, input bit v, input logic [7:0] p);
    @(negedge clk);
    frame_start = fs;
    pixel_valid = v;
    pixel_in    = p;
  endtask

  task automatic frame(input bit mode, input int maxgap);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (r + c > 0)
          repeat ($urandom_range(maxgap, 0)) cyc(1'b0, 1'b0, 8'h00);
        cyc(r == 0 && c == 0, 1'b1, val(mode, r, c));
      end
    cyc(1'b0, 1'b0, 8'h00);
  endtask

  task automatic partial(input bit mode, input int n);
    for (int k = 0; k < n; k++)
      cyc(k == 0, 1'b1, val(mode, k / W, k % W));
  endtask

  task automatic cmp_frames(input string tag);
    chk({tag, "_n"}, 72'(win_q.size()), 72'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < win_q.size(); i++)
      chk($sformatf("%s_w%0d", tag, i), win_q[i], exp_q[i]);
    win_q.delete();
    exp_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_win", win, '0);
    chk("rst_sc", 72'(start_calculations), 72'd0);
    chk("rst_fd", 72'(frame_done), 72'd0);
    chk("rst_busy", 72'(busy), 72'd0);
`ifdef SOBEL_WIN_OVERRUN_EN
    chk("rst_ovr", 72'(overrun), 72'd0);
`endif
    n_rst = 1'b1;
    idle(2);

    // back-to-back frame
    fd_cnt = 0;
    push_exp(1'b0);
    frame(1'b0, 0);
    chk("t1_fd_hi", 72'(frame_done), 72'd1);
    chk("t1_sc_last", 72'(start_calculations), 72'd1);
    chk("t1_busy_done", 72'(busy), 72'd0);
    idle(1);
    chk("t1_fd_lo", 72'(frame_done), 72'd0);
    idle(2);
    cmp_frames("t1");
    chk("t1_fd_cnt", 72'(fd_cnt), 72'd1);

    // random gaps between pixels
    fd_cnt  = 0;
    gap_cnt = 0;
    push_exp(1'b0);
    frame(1'b0, 5);
    idle(3);
    cmp_frames("t2");
    chk("t2_fd_cnt", 72'(fd_cnt), 72'd1);
    chk("t2_gap_sc", 72'(gap_cnt), 72'd0);

    // two consecutive frames
    fd_cnt = 0;
    push_exp(1'b0);
    push_exp(1'b1);
    frame(1'b0, 0);
    frame(1'b1, 0);
    idle(3);
    cmp_frames("t3");
    chk("t3_fd_cnt", 72'(fd_cnt), 72'd2);

    // reset in the middle of row 2
    fd_cnt = 0;
    partial(1'b0, 10);
    @(posedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    chk("t4_rst_win", win, '0);
    chk("t4_rst_sc", 72'(start_calculations), 72'd0);
    chk("t4_rst_busy", 72'(busy), 72'd0);
    @(negedge clk);
    n_rst = 1'b1;
    repeat (6) cyc(1'b0, 1'b1, 8'hAA);
    idle(2);
    chk("t4_ign_n", 72'(win_q.size()), 72'd0);
    chk("t4_ign_busy", 72'(busy), 72'd0);
    chk("t4_ign_win", win, '0);
`ifdef SOBEL_WIN_OVERRUN_EN
    chk("t4_ovr_set", 72'(overrun), 72'd1);
`endif
    push_exp(1'b0);
    frame(1'b0, 0);
    idle(2);
    cmp_frames("t4");
    chk("t4_fd_cnt", 72'(fd_cnt), 72'd1);
`ifdef SOBEL_WIN_OVERRUN_EN
    chk("t4_ovr_hold", 72'(overrun), 72'd1);
`endif

    // abort at (2,1) with a same-cycle valid pixel
    fd_cnt = 0;
    partial(1'b0, 9);
    push_exp(1'b1);
    frame(1'b1, 0);
    idle(3);
    cmp_frames("t5");
    chk("t5_fd_cnt", 72'(fd_cnt), 72'd1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
